// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - parallel word to NIB-bit slice serializer with LSB/MSB-first order
//
// Accepts one WIDTH-bit word on a valid/ready input, holds it, and emits it as
// WIDTH/NIB slices of NIB bits, one per output handshake. Each slice is
// word[out_index +: NIB]. The index walks upward from 0 or downward from the
// top slice, as chosen by in_msb_first for that word.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   in_valid      upstream word presented
//   in_ready      word accepted this cycle when in_valid is also high
//   in_data       word to serialize (WIDTH bits)
//   in_msb_first  slice order for this word: 0 = bit-0 slice first, 1 = top slice first
//   out_valid     out_data/out_index/out_last are valid
//   out_ready     downstream takes the current slice
//   out_data      current slice (NIB bits)
//   out_index     bit offset of the current slice (IW bits)
//   out_last      current slice is the final slice of the word

module nibble_serializer #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NIB-1:0]   out_data,
  output logic [IW-1:0]    out_index,
  output logic             out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IW-1:0] TOP_IDX  = IW'(WIDTH - NIB);
  localparam logic [IW-1:0] NIB_STEP = IW'(NIB);

  state_t           state, state_d;
  logic [WIDTH-1:0] word, word_d;
  logic [IW-1:0]    idx, idx_d;
  logic             dir, dir_d;

  logic             accept;
  logic             handshake;

  // Terminal slice depends only on registered state, so in_ready never
  // combinationally loops back through out_last. In IDLE the registers keep
  // their final values, which makes out_data/out_index/out_last hold the
  // last driven slice; reset clears them to zero.
  assign out_last  = dir ? (idx == '0) : (idx == TOP_IDX);
  assign out_data  = word[idx +: NIB];
  assign out_index = idx;
  assign out_valid = (state == SEND) && !rst;

  // Ready in IDLE, or when the final slice leaves this cycle so the next
  // word can load without a bubble.
  assign in_ready  = !rst && ((state == IDLE) || ((state == SEND) && out_last && out_ready));

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      idx   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_d;
      word  <= word_d;
      idx   <= idx_d;
      dir   <= dir_d;
    end
  end

  always_comb begin
    state_d = state;
    word_d  = word;
    idx_d   = idx;
    dir_d   = dir;

    case (state)
      IDLE: begin
        if (accept) begin
          word_d  = in_data;
          dir_d   = in_msb_first;
          idx_d   = in_msb_first ? TOP_IDX : '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (handshake && !out_last) begin
          // Terminal check above guarantees these never wrap.
          idx_d = dir ? (idx - NIB_STEP) : (idx + NIB_STEP);
        end else if (handshake && out_last) begin
          if (accept) begin
            word_d  = in_data;
            dir_d   = in_msb_first;
            idx_d   = in_msb_first ? TOP_IDX : '0;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - directed self-checking bench for nibble_serializer
`timescale 1ns/1ps

module tb_nibble_serializer;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [3:0]  out_index;
  logic        out_last;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_data;
  logic        w_in_msb_first;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [7:0]  w_out_data;
  logic [4:0]  w_out_index;
  logic        w_out_last;

  int n_checks;
  int n_pass;

  nibble_serializer #(.WIDTH(16), .NIB(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last)
  );

  nibble_serializer #(.WIDTH(32), .NIB(8)) dut_w (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (w_in_valid),
    .in_ready     (w_in_ready),
    .in_data      (w_in_data),
    .in_msb_first (w_in_msb_first),
    .out_valid    (w_out_valid),
    .out_ready    (w_out_ready),
    .out_data     (w_out_data),
    .out_index    (w_out_index),
    .out_last     (w_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sends one word from IDLE and walks its slices under the given out_ready
  // pattern (bit c = out_ready in cycle c). exp_d/exp_i pack the expected
  // slices/indices in handshake order, first slice in the top nibble.
  task automatic run_word(input string name, input logic [15:0] d, input logic m,
                          input logic [15:0] exp_d, input logic [15:0] exp_i,
                          input logic [6:0] pat, input int plen);
    int p;
    logic [3:0] e_d, e_i;
    p = 0;
    in_valid = 1'b1; in_data = d; in_msb_first = m; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'hDEAD; in_msb_first = ~m;
    for (int c = 0; c < plen; c++) begin
      out_ready = pat[c];
      @(negedge clk);
      if (p < 4) begin
        e_d = exp_d[(15 - 4*p) -: 4];
        e_i = exp_i[(15 - 4*p) -: 4];
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"},  {28'd0, out_data},  {28'd0, e_d});
        check({name, "_index"}, {28'd0, out_index}, {28'd0, e_i});
        check({name, "_last"},  {31'd0, out_last},  {31'd0, (p == 3)});
      end
      if (out_valid && out_ready) p++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_count"}, p, 32'd4);
    check({name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] b2b;
    logic [31:0] w_exp_d;
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_in_msb_first = 1'b0; w_out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_data",  {28'd0, out_data},  32'd0);
    check("rst_out_index", {28'd0, out_index}, 32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready",  {31'd0, in_ready},  32'd1);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    run_word("lsb8421", 16'h8421, 1'b0, 16'h1248, 16'h048C, 7'b0001111, 4);
    run_word("msb8421", 16'h8421, 1'b1, 16'h8421, 16'hC840, 7'b0001111, 4);
    run_word("bp_a5c3", 16'hA5C3, 1'b0, 16'h3C5A, 16'h048C, 7'b1011001, 7);

    // Back-to-back: second word loads on the first word's last handshake.
    b2b = 16'h1248;
    in_valid = 1'b1; in_data = 16'h8421; in_msb_first = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 16'h1248;
    for (int c = 0; c < 8; c++) begin
      logic [3:0] e;
      e = (c < 4) ? b2b[(15 - 4*c) -: 4] : b2b[(4*(c-4) + 3) -: 4];
      @(negedge clk);
      check("b2b_valid",    {31'd0, out_valid}, 32'd1);
      check("b2b_data",     {28'd0, out_data},  {28'd0, e});
      check("b2b_in_ready", {31'd0, in_ready},  {31'd0, (c == 3 || c == 7)});
      @(posedge clk); #1;
      if (c == 3) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("b2b_end_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-word after two slices.
    in_valid = 1'b1; in_data = 16'h8421; in_msb_first = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    check("mid_pre_index", {28'd0, out_index}, 32'd8);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready},  32'd0);
    check("mid_rst_data",     {28'd0, out_data},  32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_post_in_ready", {31'd0, in_ready},  32'd1);
    check("mid_post_valid",    {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    run_word("post00f0", 16'h00F0, 1'b0, 16'h0F00, 16'h048C, 7'b0001111, 4);

    // WIDTH=32, NIB=8 instance.
    w_exp_d = 32'h44332211;
    w_in_valid = 1'b1; w_in_data = 32'h11223344; w_in_msb_first = 1'b0; w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] e;
      e = w_exp_d[(31 - 8*c) -: 8];
      @(negedge clk);
      check("w32_valid", {31'd0, w_out_valid}, 32'd1);
      check("w32_data",  {24'd0, w_out_data},  {24'd0, e});
      check("w32_index", {27'd0, w_out_index}, 8*c);
      check("w32_last",  {31'd0, w_out_last},  {31'd0, (c == 3)});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("w32_idle_valid", {31'd0, w_out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Accepts a parallel word on a valid/ready input, holds it, and emits it one NIB-bit slice per output handshake. Each slice is selected with an indexed part-select `word[idx +: NIB]`. The index steps by NIB from bit 0 upward, or from the top slice downward. It sits directly upstream of the nibble consumers, feeding them both the slice and the bit offset it came from.

## Interface
- WIDTH, 16, input word width; must be a multiple of NIB and at least 2*NIB.
- NIB, 4, output slice width.
- IW, $clog2(WIDTH), width of the index output.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word is presented.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  word to serialize.
- in_msb_first  input  1  order for this word: 0 = bit-0 slice first, 1 = top slice first. Sampled with in_data.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream takes the slice this cycle.
- out_data  output  NIB  equals `word[out_index +: NIB]`.
- out_index  output  IW  bit offset of the current slice, always a multiple of NIB.
- out_last  output  1  current slice is the final slice of the word.

## Operation
- Registers:
  - word (WIDTH)
  - idx (IW)
  - dir (1)
  - state ∈ {IDLE, SEND}
- Reset (async, while rst=1): state=IDLE, word=0, idx=0, dir=0.
- Output values while rst=1: out_valid=0, out_last=0, out_data=0, out_index=0, in_ready=0.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in SEND when out_last && out_ready.
  - 0 otherwise, and 0 while rst=1.
- Accept = in_valid && in_ready. On accept:
  - word←in_data.
  - dir←in_msb_first.
  - idx←0 if dir=0, idx←WIDTH-NIB if dir=1.
  - state←SEND.
- SEND:
  - out_valid=1.
  - out_data=word[idx +: NIB].
  - out_index=idx.
  - out_last=1 when (dir=0 and idx==WIDTH-NIB) or (dir=1 and idx==0).
- Step = out_valid && out_ready && !out_last: idx←idx+NIB when dir=0, idx←idx-NIB when dir=1.
- Last slice handshaken (out_valid && out_ready && out_last):
  - With an accept in the same cycle: load the new word (back-to-back, no bubble).
  - Without an accept: state←IDLE.
- No handshake (out_ready=0): word, idx, dir and all outputs hold stable. out_valid never drops before its handshake.
- Index arithmetic is IW bits wide and never wraps. The terminal checks above stop stepping exactly at the last slice.
- in_data and in_msb_first are ignored unless an accept occurs.
- In IDLE, out_data, out_index and out_last hold their last driven values. out_valid=0.

## Timing
- Latency: word accepted at edge N → first slice has out_valid=1 in cycle N+1.
- Throughput: one slice per cycle with out_ready held high. A WIDTH=16 word takes 4 cycles.
- Back-to-back words have no idle cycle between the last slice of one and the first slice of the next.
- Reset mid-word: all state is discarded immediately, asynchronously. After deassertion the block is in IDLE with in_ready=1. The partial word is never resumed.
- Idle cycle: in IDLE with in_valid=0, out_valid stays 0 and nothing changes.

## Test plan
- Reset, then in_data=16'h8421 with in_msb_first=0 and out_ready=1:
  - out_data=1,2,4,8 and out_index=0,4,8,12 on consecutive cycles.
  - out_last=1 only on the 8; then out_valid=0.
- Same word with in_msb_first=1 → out_data=8,4,2,1 and out_index=12,8,4,0; out_last only on the 1.
- Backpressure:
  - 16'hA5C3 LSB-first, out_ready toggled 1,0,0,1,1,0,1.
  - Each slice holds while out_ready=0.
  - Sequence is exactly 3,C,5,A with no duplicates or skips.
- Back-to-back:
  - in_valid held with 16'h8421 then 16'h1248, out_ready=1.
  - in_ready pulses on the last slice of the first word.
  - 8 consecutive valid slices 1,2,4,8,8,4,2,1.
- Reset mid-word:
  - Assert rst asynchronously after the second slice of 16'h8421.
  - out_valid=0 immediately.
  - After release, 16'h00F0 gives 0,F,0,0.
- Parameter sweep WIDTH=32, NIB=8 with 32'h11223344 LSB-first → 44,33,22,11 at indices 0,8,16,24.
